// File: rtl/axis_output_packer.sv
`default_nettype none
// ============================================================================
// axis_output_packer: drops tkeep=0 words and repacks the rest into OUT_WORDS beats
// Rev 1.0
// ============================================================================
module axis_output_packer #(
    parameter int WORD_WIDTH   = 8,
    parameter int UNITS        = 4,
    parameter int KERNEL_H_MAX = 3,
    parameter int GROUPS       = 1,
    parameter int COPIES       = 2,
    parameter int OUT_WORDS    = 8,
    localparam int IN_WORDS    = GROUPS * (UNITS + KERNEL_H_MAX - 1) * COPIES
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [IN_WORDS*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [IN_WORDS-1:0]              s_axis_tkeep,
    input  logic                             s_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [OUT_WORDS*WORD_WIDTH-1:0]  m_axis_tdata,
    output logic [OUT_WORDS-1:0]             m_axis_tkeep,
    output logic                             m_axis_tlast
);

    localparam int BUF_WORDS = IN_WORDS + OUT_WORDS - 1;
    localparam int CNT_W     = $clog2(BUF_WORDS + 1);
    localparam int PFX_W     = $clog2(IN_WORDS + 1);
    localparam logic [CNT_W-1:0] C_OUT = CNT_W'(OUT_WORDS);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q [BUF_WORDS];
    logic [WORD_WIDTH-1:0] buf_d [BUF_WORDS];
    logic [CNT_W-1:0]      count_q, count_d, count_s, idx;
    logic [PFX_W-1:0]      prefix [IN_WORDS];
    logic [PFX_W-1:0]      pfx_acc;
    logic                  push, pop;

    // Exclusive prefix popcount: destination slot of each kept input word
    always_comb begin
        pfx_acc = '0;
        for (int i = 0; i < IN_WORDS; i++) begin
            prefix[i] = pfx_acc;
            pfx_acc   = pfx_acc + PFX_W'(s_axis_tkeep[i]);
        end
    end

    // Ready depends on registered state only, never on s_axis_tvalid
    assign s_axis_tready = aresetn && (state_q == FILL) && (count_q < C_OUT);
    assign m_axis_tvalid = (count_q >= C_OUT) || (state_q == DRAIN);
    assign m_axis_tlast  = (state_q == DRAIN) && (count_q <= C_OUT);

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    generate
        for (genvar k = 0; k < OUT_WORDS; k++) begin : g_lane
            assign m_axis_tdata[k*WORD_WIDTH +: WORD_WIDTH] = buf_q[k];
            assign m_axis_tkeep[k] = (count_q > CNT_W'(k));
        end
    endgenerate

    always_comb begin
        buf_d   = buf_q;
        count_s = count_q;
        count_d = count_q;
        state_d = state_q;
        idx     = '0;

        if (pop) begin
            for (int j = 0; j < BUF_WORDS - OUT_WORDS; j++) begin
                buf_d[j] = buf_q[j + OUT_WORDS];
            end
            for (int j = BUF_WORDS - OUT_WORDS; j < BUF_WORDS; j++) begin
                buf_d[j] = '0;
            end
            count_s = (count_q >= C_OUT) ? (count_q - C_OUT) : '0;
        end
        count_d = count_s;

        // New words land behind whatever survives a same-cycle pop
        if (push) begin
            for (int i = 0; i < IN_WORDS; i++) begin
                if (s_axis_tkeep[i]) begin
                    idx        = count_s + CNT_W'(prefix[i]);
                    buf_d[idx] = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
            count_d = count_s + CNT_W'(pfx_acc);
        end

        case (state_q)
            FILL:    if (push && s_axis_tlast) state_d = DRAIN;
            DRAIN:   if (pop && m_axis_tlast)  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= FILL;
            count_q <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_output_packer.sv
`default_nettype none
// ============================================================================
// tb_axis_output_packer: directed and scoreboarded checks of the output packer
// Rev 1.0
// ============================================================================
module tb_axis_output_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [95:0] s_tdata = '0;
    logic [11:0] s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;

    int n_checks = 0;
    int n_fail   = 0;

    axis_output_packer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast)
    );

    always #5 aclk = ~aclk;

    function automatic logic [95:0] mk96(input logic [7:0] base);
        logic [95:0] d;
        for (int i = 0; i < 12; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] mk64(input logic [7:0] base);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic send_beat(input logic [95:0] d, input logic [11:0] k, input logic l);
        int t = 0;
        @(negedge aclk);
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        while (!s_tready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        n_checks++;
        if (!s_tready) begin
            n_fail++;
            $display("FAIL send_timeout: s_tready=%b after %0d cycles, required 1", s_tready, t);
        end
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic recv_beat(input logic [63:0] ed, input logic [7:0] ek, input logic el,
                             input string name);
        int t = 0;
        @(negedge aclk);
        m_tready = 1'b1;
        while (!m_tvalid && t < 200) begin
            @(negedge aclk);
            t++;
        end
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tkeep !== ek || m_tlast !== el ||
            (m_tdata & lane_mask(ek)) !== (ed & lane_mask(ek))) begin
            n_fail++;
            $display("FAIL %s: valid=%b data=%h keep=%h last=%b, required valid=1 data=%h keep=%h last=%b",
                     name, m_tvalid, m_tdata & lane_mask(ek), m_tkeep, m_tlast,
                     ed & lane_mask(ek), ek, el);
        end
        @(posedge aclk);
        #1 m_tready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #13;
        n_checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tkeep !== 8'h00 ||
            m_tlast !== 1'b0 || m_tdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: tready=%b tvalid=%b tkeep=%h tlast=%b tdata=%h, required all 0",
                     s_tready, m_tvalid, m_tkeep, m_tlast, m_tdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: tready=%b tvalid=%b, required 1 0", s_tready, m_tvalid);
        end
    endtask

    task automatic test_full_beats();
        fork
            begin
                send_beat(mk96(8'd0), 12'hFFF, 1'b0);
                send_beat(mk96(8'd12), 12'hFFF, 1'b1);
            end
            begin
                recv_beat(mk64(8'd0),  8'hFF, 1'b0, "full_beat0");
                recv_beat(mk64(8'd8),  8'hFF, 1'b0, "full_beat1");
                recv_beat(mk64(8'd16), 8'hFF, 1'b1, "full_beat2");
            end
        join
    endtask

    task automatic test_sparse();
        send_beat(mk96(8'h40), 12'hAAA, 1'b1);
        recv_beat(64'h0000_4B49_4745_4341, 8'h3F, 1'b1, "sparse_aaa");
    endtask

    task automatic test_empty();
        send_beat(96'h0, 12'h000, 1'b1);
        recv_beat(64'h0, 8'h00, 1'b1, "empty_packet");
        @(negedge aclk);
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_back_to_fill: tready=%b tvalid=%b, required 1 0", s_tready, m_tvalid);
        end
    endtask

    task automatic test_boundary();
        send_beat(mk96(8'hA0), 12'h07F, 1'b0);
        @(negedge aclk);
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_seven: tready=%b tvalid=%b, required 1 0", s_tready, m_tvalid);
        end
        send_beat(mk96(8'hB0), 12'hFFF, 1'b1);
        @(negedge aclk);
        n_checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || dut.count_q !== 5'd19) begin
            n_fail++;
            $display("FAIL boundary_full: tready=%b tvalid=%b count=%0d, required 0 1 19",
                     s_tready, m_tvalid, dut.count_q);
        end
        recv_beat(64'hB0A6_A5A4_A3A2_A1A0, 8'hFF, 1'b0, "boundary_pop0");
        recv_beat(64'hB8B7_B6B5_B4B3_B2B1, 8'hFF, 1'b0, "boundary_pop1");
        recv_beat(64'h0000_0000_00BB_BAB9, 8'h07, 1'b1, "boundary_pop2");
    endtask

    task automatic test_random();
        logic [7:0]  q[$];
        int          bounds[$];
        int          tin = 0, tout = 0, sent = 0, cyc = 0, n;
        logic        have = 1'b0, stall_prev = 1'b0;
        logic [63:0] pd = '0;
        logic [7:0]  pk = '0;
        logic        pl = 1'b0;
        logic [95:0] d = '0;
        logic [11:0] k = '0;
        logic        l = 1'b0;
        int          r;
        while ((sent < 100 || q.size() > 0 || bounds.size() > 0) && cyc < 5000) begin
            @(negedge aclk);
            cyc++;
            if (stall_prev) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl) begin
                    n_fail++;
                    $display("FAIL rand_stall_stable: valid=%b data=%h keep=%h last=%b, required 1 %h %h %b",
                             m_tvalid, m_tdata, m_tkeep, m_tlast, pd, pk, pl);
                end
            end
            if (!have && sent < 100) begin
                for (int i = 0; i < 12; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
                r = int'($urandom_range(0, 7));
                k = (r == 0) ? 12'h000 : (r == 1) ? 12'hFFF : 12'($urandom_range(0, 4095));
                l = (sent == 49 || sent == 99);
                have = 1'b1;
            end
            s_tvalid = have; s_tdata = d; s_tkeep = k; s_tlast = l;
            m_tready = 1'($urandom_range(0, 1));
            if (m_tvalid && m_tready) begin
                n = 0;
                for (int i = 0; i < 8; i++) if (m_tkeep[i]) n++;
                n_checks++;
                if (m_tkeep !== 8'((16'h1 << n) - 16'h1)) begin
                    n_fail++;
                    $display("FAIL rand_keep_contig: keep=%h, required contiguous from lane 0", m_tkeep);
                end
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_extra_word: lane %0d data=%h, required no word", i, m_tdata[i*8 +: 8]);
                    end else if (m_tdata[i*8 +: 8] !== q[0]) begin
                        n_fail++;
                        $display("FAIL rand_data: lane %0d data=%h, required %h", i, m_tdata[i*8 +: 8], q[0]);
                        void'(q.pop_front());
                    end else begin
                        void'(q.pop_front());
                    end
                end
                tout += n;
                n_checks++;
                if (m_tlast) begin
                    if (bounds.size() == 0 || tout != bounds[0]) begin
                        n_fail++;
                        $display("FAIL rand_tlast: words out=%0d, required packet end at %0d",
                                 tout, (bounds.size() > 0) ? bounds[0] : -1);
                    end
                    if (bounds.size() > 0) void'(bounds.pop_front());
                end else if (m_tkeep !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL rand_full_keep: keep=%h without tlast, required ff", m_tkeep);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            pd = m_tdata; pk = m_tkeep; pl = m_tlast;
            if (have && s_tready) begin
                for (int i = 0; i < 12; i++) if (k[i]) begin q.push_back(d[i*8 +: 8]); tin++; end
                if (l) bounds.push_back(tin);
                have = 1'b0;
                sent++;
            end
        end
        n_checks++;
        if (cyc >= 5000 || q.size() != 0 || tin != tout) begin
            n_fail++;
            $display("FAIL rand_complete: cycles=%0d left=%0d in=%0d out=%0d, required drained in<5000 and in==out",
                     cyc, q.size(), tin, tout);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
    endtask

    task automatic test_async_reset();
        send_beat(mk96(8'h10), 12'h01F, 1'b0);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        n_checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tkeep !== 8'h00 ||
            m_tlast !== 1'b0 || m_tdata !== 64'h0 || dut.count_q !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset: tready=%b tvalid=%b keep=%h last=%b data=%h count=%0d, required all 0",
                     s_tready, m_tvalid, m_tkeep, m_tlast, m_tdata, dut.count_q);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        send_beat(mk96(8'h80), 12'h0FF, 1'b1);
        recv_beat(mk64(8'h80), 8'hFF, 1'b1, "after_reset_packet");
    endtask

    initial begin
        test_reset();
        test_full_beats();
        test_sparse();
        test_empty();
        test_boundary();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
